// File: rtl/reg_rd_resp_pkg.sv
// Shared types and constants for the register read-response stage.
`default_nettype none

package reg_rd_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] RESP_OK        = 2'b00;
   localparam logic [1:0] RESP_DEC_MISS  = 2'b01;
   localparam logic [1:0] RESP_MULTI_HOT = 2'b10;

   localparam int CNT_W = 4;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

`default_nettype wire

// File: rtl/one_hot_chk.sv
// Combinational classifier: select vector is all-zero, exactly one-hot, or multi-hot.
`default_nettype none

module one_hot_chk #(
   parameter int CNT = 5
) (
   input  logic [CNT-1:0] vec,
   output logic           zero,
   output logic           one_hot,
   output logic           multi_hot
);

   logic any_below;

   // A set bit seen while a lower bit was already set marks the vector multi-hot.
   always_comb begin
      any_below = 1'b0;
      multi_hot = 1'b0;
      for (int i = 0; i < CNT; i++) begin
         if (vec[i] && any_below) multi_hot = 1'b1;
         any_below = any_below | vec[i];
      end
   end

   assign zero    = ~|vec;
   assign one_hot = ~zero & ~multi_hot;

endmodule

`default_nettype wire

// File: rtl/reg_rd_resp_stage.sv
// Drives the register read-mux select, waits out its settle latency and
// returns the sampled data as a registered, flow-controlled response.
`default_nettype none

module reg_rd_resp_stage
   import reg_rd_resp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT   = 5,
   parameter int LAT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_vld,
   output logic             req_rdy,
   input  logic [CNT-1:0]   req_sel,
   output logic [CNT-1:0]   mux_sel,
   input  logic [WIDTH-1:0] mux_dout,
   output logic             resp_vld,
   input  logic             resp_rdy,
   output logic [WIDTH-1:0] resp_data,
   output logic [1:0]       resp_err
);

   state_t         state;
   cnt_t           cnt;
   logic [CNT-1:0] sel_q;
   logic           sel_zero;
   logic           sel_one;
   logic           sel_multi;

   one_hot_chk #(
      .CNT (CNT)
   ) u_one_hot_chk (
      .vec       (req_sel),
      .zero      (sel_zero),
      .one_hot   (sel_one),
      .multi_hot (sel_multi)
   );

   // Pure state decodes; reset only gates readiness so nothing is accepted during it.
   assign req_rdy = (state == IDLE) && !rst;
   assign mux_sel = (state == WAIT) ? sel_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sel_q     <= '0;
         resp_vld  <= 1'b0;
         resp_data <= '0;
         resp_err  <= RESP_OK;
      end else begin
         case (state)
            IDLE: begin
               if (req_vld) begin
                  sel_q <= req_sel;
                  cnt   <= CNT_W'(LAT);
                  if (sel_one || sel_multi) begin
                     state    <= WAIT;
                     resp_err <= sel_one ? RESP_OK : RESP_MULTI_HOT;
                  end else begin
                     state     <= RESP;
                     resp_vld  <= 1'b1;
                     resp_data <= '0;
                     resp_err  <= RESP_DEC_MISS;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  resp_data <= mux_dout;
                  resp_vld  <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_rdy) begin
                  resp_vld <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/reg_rd_resp_stage.md
# reg_rd_resp_stage

Read-response stage that drives the one-hot select of the register read-data mux and turns its combinational output into a registered, flow-controlled read response. It sits between the address decoder and the register file. Upstream it accepts a decoded one-hot select with a valid/ready handshake. It holds that select on the mux for a programmable settle latency, then presents data plus an error code to the bus-side response channel.

## Interface
- `WIDTH`, 32: read-data width; must equal the mux `WIDTH`.
- `CNT`, 5: number of register slots; must equal the mux `CNT`.
- `LAT`, 1: cycles mux output needs to settle after `mux_sel` changes; legal range 0..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_vld` in 1: decoder has a read request.
- `req_rdy` out 1: stage can accept a request.
- `req_sel` in CNT: one-hot slot select from the decoder; all-zero means address miss.
- `mux_sel` out CNT: select driven to the read-data mux.
- `mux_dout` in WIDTH: read data from the mux.
- `resp_vld` out 1: response valid.
- `resp_rdy` in 1: bus side accepts the response.
- `resp_data` out WIDTH: read data.
- `resp_err` out 2: 00 OK, 01 decode miss, 10 multi-hot select.

## Operation
- **States:**
  - IDLE: `req_rdy`=1 and `mux_sel`=0.
  - WAIT: `mux_sel`=sel_q and the settle counter runs.
  - RESP: `resp_vld`=1 and `mux_sel`=0.
- **IDLE, on `req_vld` & `req_rdy`:**
  - Capture `req_sel` into sel_q.
  - Classify the request:
    - zero select: go to RESP with `resp_data`=0 and `resp_err`=01.
    - more than one bit set: flag error 10 and go to WAIT; data is still sampled, giving the bitwise OR from the mux.
    - exactly one bit set: go to WAIT with error 00.
  - Load the counter with `LAT`.
- **WAIT:**
  - Counter decrements each cycle.
  - On the cycle the counter is 0, `mux_dout` is registered into `resp_data` and the state moves to RESP.
- **RESP:**
  - Hold `resp_data` and `resp_err` stable while `resp_vld` & !`resp_rdy`.
  - On `resp_rdy`, go to IDLE.
  - `resp_data` keeps its last value after the handshake; it is don't-care when `resp_vld`=0.
- `req_rdy` is high only in IDLE, so no request is accepted while a response is pending.
- `req_vld` in WAIT or RESP is ignored; the upstream must hold it per valid/ready rules.
- **Reset values:**
  - `req_rdy`=0 while `rst` is high, and 1 in the first cycle after release.
  - `mux_sel`=0, `resp_vld`=0, `resp_data`=0, `resp_err`=00.
  - State IDLE and counter 0.
- **Reset mid-transaction:** the in-flight request is dropped and no response is ever issued for it.

## Timing
- Accept edge is at the end of cycle 0.
- `mux_sel` is driven in cycles 1..1+LAT.
- Data is sampled at the end of cycle 1+LAT.
- `resp_vld` rises in cycle 2+LAT, so accept-to-response latency is 2+LAT.
- Decode miss: `resp_vld` in cycle 1, and `mux_sel` is never driven.
- `resp_rdy` already high when `resp_vld` rises: single-cycle response, `req_rdy` back high in the next cycle.
- Back-to-back throughput: one request per 3+LAT cycles, or 2 cycles for misses.
- `mux_sel`, `resp_*` and `req_rdy` are registers or pure state decodes, with no combinational path from `req_vld` or `resp_rdy`.

## Structure
- Package `reg_rd_resp_pkg`:
  - state enum {IDLE, WAIT, RESP};
  - `resp_err` codes RESP_OK, RESP_DEC_MISS, RESP_MULTI_HOT;
  - counter width constant (4 bits).
- One natural sub-module, `one_hot_chk`: combinational zero / one-hot / multi-hot classifier on `CNT` bits.
- Everything else lives in the single module.

## Test plan
- **Single read:** `LAT`=1, `req_sel`=5'b00100, mux returns 32'hDEAD_BEEF, `resp_rdy`=1. Required: `mux_sel`=00100 in cycles 1–2, `resp_vld` in cycle 3 with data DEAD_BEEF and err 00, `req_rdy` high again in cycle 4.
- **Decode miss:** `req_sel`=0. Required: `resp_vld` in cycle 1, data 0, err 01, `mux_sel` stays 0 throughout.
- **Multi-hot:** `req_sel`=5'b00011, slot0=32'h0F, slot1=32'hF0. Required: data 32'hFF, err 10.
- **Backpressure:** `resp_rdy` held low for 4 cycles after `resp_vld` rises. Required: data and err stable, `req_rdy`=0 throughout, and a new `req_vld` is not accepted until the cycle after the `resp_rdy` handshake.
- **`LAT`=0 and `LAT`=15 sweep:** back-to-back requests to slots 0..4. Required: latency exactly 2+LAT per request, with data matching each slot in order.
- **Reset mid-WAIT:** assert `rst` in cycle 2 with `LAT`=3. Required: in the next cycle `mux_sel`=0, `resp_vld`=0 and the state is IDLE; no response is ever issued for the dropped request.
